// File: rtl/vx_commit_gather_pkg.sv
// Shared definitions for the commit gather stage: arbitration modes and unit-index sizing.
package vx_commit_gather_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of a unit index; a single-unit build still carries a 1-bit index.
  function automatic int unit_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_commit_gather_if.sv
// Commit-side bus of the gather stage: NUM_UNITS input channels and one merged output port.
interface vx_commit_gather_if #(
  parameter int NUM_UNITS = 4,
  parameter int DATAW     = 64,
  parameter int UNIT_IDW  = 2
);

  // valid/ready: a beat moves on a clock edge where valid && ready. A source
  // holds valid/data/eop stable until accepted; ready never depends on valid.
  logic [NUM_UNITS-1:0]       in_valid;
  logic [NUM_UNITS*DATAW-1:0] in_data;
  logic [NUM_UNITS-1:0]       in_eop;
  logic [NUM_UNITS-1:0]       in_ready;
  logic                       out_valid;
  logic [DATAW-1:0]           out_data;
  logic                       out_eop;
  logic [UNIT_IDW-1:0]        out_unit;
  logic                       out_ready;

  modport master (
    input  in_valid, in_data, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_eop, out_unit
  );

  modport slave (
    output in_valid, in_data, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_eop, out_unit
  );

endinterface

// File: rtl/vx_commit_gather_fifo.sv
// Single-channel elastic FIFO; full/empty come from a registered occupancy count.
module vx_commit_gather_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when the same edge pops.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vx_commit_gather.sv
// Merges NUM_UNITS commit streams into one port, keeping multi-beat packets contiguous.
module vx_commit_gather
  import vx_commit_gather_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DATAW     = 64,
  parameter int DEPTH     = 2,
  parameter int ARB_MODE  = ARB_RR,
  parameter int CNTW      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_commit_gather_if.master        bus,
  input  logic                      clear_stats,
  output logic [NUM_UNITS*CNTW-1:0] stall_cnt,
  output logic [0:0]                lock_state
);

  localparam int UNIT_IDW = unit_idw(NUM_UNITS);
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  typedef struct packed {
    logic             eop;
    logic [DATAW-1:0] data;
  } gather_beat_t;

  gather_beat_t         head [NUM_UNITS];
  logic [NUM_UNITS-1:0] full;
  logic [NUM_UNITS-1:0] empty;
  logic [NUM_UNITS-1:0] pop;
  logic [0:0]           state;
  logic [UNIT_IDW-1:0]  lock_unit;
  logic [UNIT_IDW-1:0]  rr_ptr;
  logic [UNIT_IDW-1:0]  grant;
  logic [UNIT_IDW-1:0]  next_ptr;
  logic                 grant_valid;
  logic                 load;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    gather_beat_t    push_beat;
    logic [CNTW-1:0] cnt;

    assign push_beat = {bus.in_eop[i], bus.in_data[i*DATAW +: DATAW]};

    vx_commit_gather_fifo #(
      .WIDTH ($bits(gather_beat_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.in_valid[i]),
      .push_data (push_beat),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );

    assign pop[i]          = load && (grant == UNIT_IDW'(i));
    assign bus.in_ready[i] = !full[i];
    assign stall_cnt[i*CNTW +: CNTW] = cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                       cnt <= '0;
      else if (clear_stats)                             cnt <= '0;
      else if (bus.in_valid[i] && full[i] && cnt != '1) cnt <= cnt + CNTW'(1);
    end
  end

  // Reverse scans so the lowest offset (closest to the start point) wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (state == ST_LOCKED) begin
      grant       = lock_unit;
      grant_valid = !empty[lock_unit];
    end else if (ARB_MODE == ARB_FIXED) begin
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
        if (!empty[k]) begin
          grant       = UNIT_IDW'(k);
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
        if (!empty[(int'(rr_ptr) + k) % NUM_UNITS]) begin
          grant       = UNIT_IDW'((int'(rr_ptr) + k) % NUM_UNITS);
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign load       = grant_valid && (!bus.out_valid || bus.out_ready);
  assign next_ptr   = (int'(grant) == NUM_UNITS - 1) ? '0 : grant + UNIT_IDW'(1);
  assign lock_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_eop   <= 1'b0;
      bus.out_unit  <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= head[grant].data;
      bus.out_eop   <= head[grant].eop;
      bus.out_unit  <= grant;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // The round-robin start point only moves when a packet completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_UNLOCKED;
      lock_unit <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (head[grant].eop) begin
        state <= ST_UNLOCKED;
        if (ARB_MODE == ARB_RR) rr_ptr <= next_ptr;
      end else begin
        state     <= ST_LOCKED;
        lock_unit <= grant;
      end
    end
  end

endmodule

// File: tb/tb_vx_commit_gather.sv
// Directed bench: a round-robin instance (4-bit counters) and a fixed-priority instance share stimulus.
module tb_vx_commit_gather;
  import vx_commit_gather_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int UIDW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_eop;
  logic [N*DW-1:0] in_data;
  logic            out_ready;
  logic            clear_stats;
  logic [N*4-1:0]  stall_rr;
  logic [N*16-1:0] stall_fp;
  logic [0:0]      lock_rr;
  logic [0:0]      lock_fp;

  int n_cmp  = 0;
  int n_fail = 0;

  vx_commit_gather_if #(.NUM_UNITS(N), .DATAW(DW), .UNIT_IDW(UIDW)) br ();
  vx_commit_gather_if #(.NUM_UNITS(N), .DATAW(DW), .UNIT_IDW(UIDW)) bf ();

  assign br.in_valid  = in_valid;
  assign br.in_data   = in_data;
  assign br.in_eop    = in_eop;
  assign br.out_ready = out_ready;
  assign bf.in_valid  = in_valid;
  assign bf.in_data   = in_data;
  assign bf.in_eop    = in_eop;
  assign bf.out_ready = out_ready;

  vx_commit_gather #(
    .NUM_UNITS(N), .DATAW(DW), .DEPTH(2), .ARB_MODE(ARB_RR), .CNTW(4)
  ) u_rr (
    .clk(clk), .reset(reset), .bus(br), .clear_stats(clear_stats),
    .stall_cnt(stall_rr), .lock_state(lock_rr)
  );

  vx_commit_gather #(
    .NUM_UNITS(N), .DATAW(DW), .DEPTH(2), .ARB_MODE(ARB_FIXED), .CNTW(16)
  ) u_fp (
    .clk(clk), .reset(reset), .bus(bf), .clear_stats(clear_stats),
    .stall_cnt(stall_fp), .lock_state(lock_fp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    in_eop   = '0;
    in_data  = '0;
  endtask

  task automatic beat(input int u, input logic [DW-1:0] d, input logic e);
    in_valid[u]          = 1'b1;
    in_data[u*DW +: DW]  = d;
    in_eop[u]            = e;
  endtask

  task automatic apply_reset();
    reset       = 1'b0;
    idle();
    out_ready   = 1'b0;
    clear_stats = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    apply_reset();
    check("rst_in_ready_rr", br.in_ready, 4'hF);
    check("rst_in_ready_fp", bf.in_ready, 4'hF);
    check("rst_out_valid", br.out_valid, 1'b0);
    check("rst_out_data", br.out_data, 64'h0);
    check("rst_out_eop", br.out_eop, 1'b0);
    check("rst_out_unit", br.out_unit, 2'd0);
    check("rst_stall_rr", stall_rr, 16'h0);
    check("rst_stall_fp", stall_fp, 64'h0);
    check("rst_lock_rr", lock_rr, 1'b0);
    check("rst_lock_fp", lock_fp, 1'b0);

    // Single beat from unit 2: two-cycle latency
    out_ready = 1'b1;
    beat(2, 64'hA5, 1'b1);
    tick();
    idle();
    check("single_latency_valid", br.out_valid, 1'b0);
    check("single_in_ready", br.in_ready, 4'hF);
    tick();
    check("single_valid", br.out_valid, 1'b1);
    check("single_data", br.out_data, 64'hA5);
    check("single_unit", br.out_unit, 2'd2);
    check("single_eop", br.out_eop, 1'b1);
    tick();
    check("single_drained", br.out_valid, 1'b0);

    // Round-robin fairness with all units streaming single-beat packets
    apply_reset();
    out_ready = 1'b1;
    for (int u = 0; u < N; u++) beat(u, 64'h10 + 64'(u), 1'b1);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check("rr_valid", br.out_valid, 1'b1);
      check("rr_unit", br.out_unit, 64'(i % 4));
      check("rr_data", br.out_data, 64'h10 + 64'(i % 4));
      tick();
    end
    idle();

    // Fixed priority: unit 1 drains before unit 3
    apply_reset();
    beat(1, 64'h11, 1'b1);
    beat(3, 64'h31, 1'b1);
    tick();
    beat(1, 64'h12, 1'b1);
    beat(3, 64'h32, 1'b1);
    tick();
    idle();
    check("fp_first_unit", bf.out_unit, 2'd1);
    check("fp_first_data", bf.out_data, 64'h11);
    check("fp_in_ready_full3", bf.in_ready, 4'b0111);
    tick();
    check("fp_hold_valid", bf.out_valid, 1'b1);
    check("fp_hold_data", bf.out_data, 64'h11);
    out_ready = 1'b1;
    tick();
    check("fp_second_unit", bf.out_unit, 2'd1);
    check("fp_second_data", bf.out_data, 64'h12);
    tick();
    check("fp_third_unit", bf.out_unit, 2'd3);
    check("fp_third_data", bf.out_data, 64'h31);
    tick();
    check("fp_fourth_data", bf.out_data, 64'h32);
    tick();
    check("fp_drained", bf.out_valid, 1'b0);

    // Packet lock: unit 0 three-beat packet with a gap, unit 1 waiting
    apply_reset();
    out_ready = 1'b1;
    beat(0, 64'hA1, 1'b0);
    beat(1, 64'hB1, 1'b1);
    tick();
    beat(0, 64'hA2, 1'b0);
    in_valid[1] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    check("lock_b1_unit", br.out_unit, 2'd0);
    check("lock_b1_data", br.out_data, 64'hA1);
    check("lock_b1_eop", br.out_eop, 1'b0);
    check("lock_state_set", lock_rr, 1'b1);
    tick();
    check("lock_b2_unit", br.out_unit, 2'd0);
    check("lock_b2_data", br.out_data, 64'hA2);
    tick();
    check("lock_bubble1", br.out_valid, 1'b0);
    check("lock_state_held", lock_rr, 1'b1);
    beat(0, 64'hA3, 1'b1);
    tick();
    in_valid[0] = 1'b0;
    check("lock_bubble2", br.out_valid, 1'b0);
    tick();
    check("lock_b3_valid", br.out_valid, 1'b1);
    check("lock_b3_unit", br.out_unit, 2'd0);
    check("lock_b3_data", br.out_data, 64'hA3);
    check("lock_b3_eop", br.out_eop, 1'b1);
    check("lock_state_clear", lock_rr, 1'b0);
    tick();
    check("lock_u1_unit", br.out_unit, 2'd1);
    check("lock_u1_data", br.out_data, 64'hB1);
    tick();
    check("lock_drained", br.out_valid, 1'b0);

    // Back-pressure, stall counting, saturation and clear
    apply_reset();
    beat(0, 64'hC0, 1'b1);
    tick();
    check("bp_ready_e1", br.in_ready, 4'hF);
    tick();
    check("bp_out_valid", br.out_valid, 1'b1);
    check("bp_ready_e2", br.in_ready, 4'hF);
    tick();
    check("bp_ready_full", br.in_ready, 4'hE);
    check("bp_stall_zero", stall_rr, 16'h0);
    for (int i = 0; i < 7; i++) tick();
    check("bp_stall_7", stall_rr, 16'h0007);
    check("bp_hold_data", br.out_data, 64'hC0);
    check("bp_hold_valid", br.out_valid, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("bp_stall_sat", stall_rr, 16'h000F);
    clear_stats = 1'b1;
    tick();
    check("bp_stall_clear", stall_rr, 16'h0);
    clear_stats = 1'b0;
    idle();
    tick();
    check("bp_stall_after_clear", stall_rr, 16'h0);

    // Asynchronous reset while locked with beats buffered
    apply_reset();
    beat(0, 64'hD1, 1'b0);
    tick();
    beat(0, 64'hD2, 1'b0);
    tick();
    beat(0, 64'hD3, 1'b0);
    tick();
    idle();
    check("ar_locked", lock_rr, 1'b1);
    check("ar_full", br.in_ready, 4'hE);
    #3;
    reset = 1'b0;
    #1;
    check("ar_out_valid", br.out_valid, 1'b0);
    check("ar_in_ready", br.in_ready, 4'hF);
    check("ar_lock", lock_rr, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    beat(2, 64'hE1, 1'b1);
    tick();
    idle();
    tick();
    check("ar_new_valid", br.out_valid, 1'b1);
    check("ar_new_unit", br.out_unit, 2'd2);
    check("ar_new_data", br.out_data, 64'hE1);
    tick();
    check("ar_no_stale", br.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
